// File: rtl/generador_frecuencia.sv
// Programmable 50%-duty square-wave generator. The half period is fre_act*PRESCALE
// clocks, and a new divisor is taken only at a half-period boundary so the output never glitches.
module generador_frecuencia #(
  parameter int WIDTH    = 11,
  parameter int PRESCALE = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] fre_sel,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] fre_act,
  output logic             activo
);

  localparam int PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  typedef enum logic {Idle, Run} state_t;

  state_t           state_q;
  logic [PreW-1:0]  preCnt_q;
  logic [WIDTH-1:0] cnt_q;
  logic             clkOut_q;
  logic             tick_q;
  logic [WIDTH-1:0] freAct_q;
  logic             activo_q;

  assign clk_out = clkOut_q;
  assign tick    = tick_q;
  assign fre_act = freAct_q;
  assign activo  = activo_q;

  // The prescaler wraps first; the divisor counter advances once per prescaler wrap.
  // A zero divisor sampled at a boundary still pulses tick on the way back to Idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= Idle;
      preCnt_q <= '0;
      cnt_q    <= '0;
      clkOut_q <= 1'b0;
      tick_q   <= 1'b0;
      freAct_q <= '0;
      activo_q <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          clkOut_q <= 1'b0;
          tick_q   <= 1'b0;
          preCnt_q <= '0;
          cnt_q    <= '0;
          if (en && (fre_sel != '0)) begin
            state_q  <= Run;
            activo_q <= 1'b1;
            freAct_q <= fre_sel;
          end else begin
            activo_q <= 1'b0;
            freAct_q <= '0;
          end
        end
        Run: begin
          if (!en) begin
            state_q  <= Idle;
            activo_q <= 1'b0;
            clkOut_q <= 1'b0;
            freAct_q <= '0;
            preCnt_q <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
          end else if (preCnt_q != PreMax) begin
            preCnt_q <= preCnt_q + PreW'(1);
            tick_q   <= 1'b0;
          end else begin
            preCnt_q <= '0;
            if (cnt_q != (freAct_q - WIDTH'(1))) begin
              cnt_q  <= cnt_q + WIDTH'(1);
              tick_q <= 1'b0;
            end else begin
              cnt_q  <= '0;
              tick_q <= 1'b1;
              if (fre_sel != '0) begin
                clkOut_q <= ~clkOut_q;
                freAct_q <= fre_sel;
              end else begin
                state_q  <= Idle;
                activo_q <= 1'b0;
                clkOut_q <= 1'b0;
                freAct_q <= '0;
              end
            end
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_generador_frecuencia.sv
// Bench for generador_frecuencia: two instances (PRESCALE 1 and 3) share one stimulus
// stream and are compared every cycle against a remaining-clocks model, plus literal checks.
module tb_generador_frecuencia;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] freSel;

  logic         clkOut [2];
  logic         tick   [2];
  logic [W-1:0] freAct [2];
  logic         activo [2];

  int checkCount = 0;
  int passCount  = 0;
  bit checkOn    = 1'b0;

  // Model state per instance: idx 0 is PRESCALE=1, idx 1 is PRESCALE=3.
  bit mRun [2];
  bit mOut [2];
  bit mTick[2];
  int mAct [2];
  int mRem [2];

  always #5 clk = ~clk;

  generador_frecuencia #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .fre_sel(freSel),
    .clk_out(clkOut[0]), .tick(tick[0]), .fre_act(freAct[0]), .activo(activo[0])
  );

  generador_frecuencia #(.WIDTH(W), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .fre_sel(freSel),
    .clk_out(clkOut[1]), .tick(tick[1]), .fre_act(freAct[1]), .activo(activo[1])
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input bit r, input bit e, input int fs);
    rst    = r;
    en     = e;
    freSel = W'(fs);
  endtask

  // Model: each half period is simply a countdown of fre_act*PRESCALE clocks.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (k == 0) ? 1 : 3;
      if (rst) begin
        mRun[k] = 0; mOut[k] = 0; mTick[k] = 0; mAct[k] = 0; mRem[k] = 0;
      end else if (!mRun[k]) begin
        mOut[k] = 0; mTick[k] = 0;
        if (en && freSel != 0) begin
          mRun[k] = 1; mAct[k] = int'(freSel); mRem[k] = int'(freSel) * p;
        end else begin
          mAct[k] = 0;
        end
      end else if (!en) begin
        mRun[k] = 0; mOut[k] = 0; mTick[k] = 0; mAct[k] = 0;
      end else begin
        mRem[k] = mRem[k] - 1;
        if (mRem[k] == 0) begin
          mTick[k] = 1;
          if (freSel != 0) begin
            mOut[k] = ~mOut[k]; mAct[k] = int'(freSel); mRem[k] = int'(freSel) * p;
          end else begin
            mRun[k] = 0; mOut[k] = 0; mAct[k] = 0;
          end
        end else begin
          mTick[k] = 0;
        end
      end
    end
    if (rst) checkOn = 1'b1;
  end

  always @(negedge clk) begin
    if (checkOn) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("model clk_out[%0d]", k), int'(clkOut[k]), int'(mOut[k]));
        checkOutput($sformatf("model tick[%0d]", k),    int'(tick[k]),   int'(mTick[k]));
        checkOutput($sformatf("model fre_act[%0d]", k), int'(freAct[k]), mAct[k]);
        checkOutput($sformatf("model activo[%0d]", k),  int'(activo[k]), int'(mRun[k]));
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset clk_out", int'(clkOut[0]), 0);
    checkOutput("reset tick",    int'(tick[0]),   0);
    checkOutput("reset fre_act", int'(freAct[0]), 0);
    checkOutput("reset activo",  int'(activo[0]), 0);

    // fre_sel=4 at PRESCALE=1: rise 4 clocks after entry, fall 4 later.
    applyStimulus(0, 1, 4);
    @(negedge clk);
    checkOutput("entry activo",  int'(activo[0]), 1);
    checkOutput("entry fre_act", int'(freAct[0]), 4);
    checkOutput("entry clk_out", int'(clkOut[0]), 0);
    repeat (3) @(negedge clk);
    checkOutput("pre-rise clk_out", int'(clkOut[0]), 0);
    @(negedge clk);
    checkOutput("rise clk_out", int'(clkOut[0]), 1);
    checkOutput("rise tick",    int'(tick[0]),   1);
    @(negedge clk);
    checkOutput("after rise tick", int'(tick[0]), 0);
    repeat (2) @(negedge clk);
    checkOutput("high clk_out", int'(clkOut[0]), 1);
    @(negedge clk);
    checkOutput("fall clk_out", int'(clkOut[0]), 0);
    checkOutput("fall tick",    int'(tick[0]),   1);

    // Divisor change mid-half only applies at the next boundary.
    applyStimulus(0, 1, 2);
    repeat (3) @(negedge clk);
    checkOutput("held clk_out", int'(clkOut[0]), 0);
    checkOutput("held fre_act", int'(freAct[0]), 4);
    @(negedge clk);
    checkOutput("reload clk_out", int'(clkOut[0]), 1);
    checkOutput("reload fre_act", int'(freAct[0]), 2);
    repeat (2) @(negedge clk);
    checkOutput("short half clk_out", int'(clkOut[0]), 0);
    checkOutput("short half tick",    int'(tick[0]),   1);

    // Mid-run reset, then fre_sel=1 (clk/2) and stop via fre_sel=0.
    applyStimulus(1, 1, 1);
    @(negedge clk);
    checkOutput("midrun reset activo", int'(activo[0]), 0);
    checkOutput("midrun reset fre_act", int'(freAct[0]), 0);
    applyStimulus(0, 1, 1);
    @(negedge clk);
    checkOutput("div1 entry clk_out", int'(clkOut[0]), 0);
    @(negedge clk);
    checkOutput("div1 clk_out e1", int'(clkOut[0]), 1);
    checkOutput("div1 tick e1",    int'(tick[0]),   1);
    @(negedge clk);
    checkOutput("div1 clk_out e2", int'(clkOut[0]), 0);
    checkOutput("div1 tick e2",    int'(tick[0]),   1);
    applyStimulus(0, 1, 0);
    @(negedge clk);
    checkOutput("stop activo",  int'(activo[0]), 0);
    checkOutput("stop tick",    int'(tick[0]),   1);
    checkOutput("stop fre_act", int'(freAct[0]), 0);
    @(negedge clk);
    checkOutput("silent tick",   int'(tick[0]),   0);
    checkOutput("silent activo", int'(activo[0]), 0);

    // Randomized phase, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        int fs;
        bit e;
        bit r;
        fs = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
        e  = ($urandom_range(0, 9) != 0);
        r  = ($urandom_range(0, 40) == 0);
        applyStimulus(r, e, fs);
      end else if (rst) begin
        applyStimulus(0, en, int'(freSel));
      end
      @(negedge clk);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
